// File: rtl/prog_mem.sv
// Program memory: flop array with a combinational fetch port and a full-image serial loader.
// Defining PROG_MEM_CHECKSUM_EN adds a trailing checksum word after the image and drives ld_err.
module prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dout,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic              ld_err
);

    // state | meaning
    // RUN   | CPU fetches from memory; loader idle
    // LOAD  | accepting image words, one per ld_valid cycle
    // CHECK | accepting the checksum word (checksum build only)

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

`ifdef PROG_MEM_CHECKSUM_EN
    typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, CHECK = 2'd2} state_t;
    logic [DATA_W-1:0] sum;
    logic              err_q;
`else
    typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= RUN;
            ptr     <= '0;
            ld_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`ifdef PROG_MEM_CHECKSUM_EN
            sum     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            ld_done <= 1'b0;
            case (state)
                RUN: begin
                    if (ld_start) begin
                        state <= LOAD;
                        ptr   <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
                        sum   <= '0;
                        err_q <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        mem[ptr] <= ld_data;
`ifdef PROG_MEM_CHECKSUM_EN
                        sum      <= sum + ld_data;
`endif
                        // The pointer parks on the last slot instead of wrapping.
                        if (ptr == PTR_LAST) begin
`ifdef PROG_MEM_CHECKSUM_EN
                            state   <= CHECK;
`else
                            state   <= RUN;
                            ld_done <= 1'b1;
`endif
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
`ifdef PROG_MEM_CHECKSUM_EN
                CHECK: begin
                    if (ld_valid) begin
                        err_q   <= (ld_data != sum);
                        state   <= RUN;
                        ld_done <= 1'b1;
                    end
                end
`endif
                default: state <= RUN;
            endcase
        end
    end

    assign ld_ready = (state != RUN);
    assign cpu_hold = (state != RUN);
    assign dout     = (state == RUN) ? mem[address] : '0;

`ifdef PROG_MEM_CHECKSUM_EN
    assign ld_err = err_q;
`else
    assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: reset sweep, back-to-back and stalled loads,
// mid-load reset, ignored ld_start during LOAD, and checksum cases when enabled.
module tb_prog_mem;

    logic       clk;
    logic       n_reset;
    logic [3:0] address;
    logic [7:0] dout;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       cpu_hold;
    logic       ld_done;
    logic       ld_err;

    int checks = 0;
    int errors = 0;

`ifdef PROG_MEM_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    prog_mem #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .address  (address),
        .dout     (dout),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .ld_done  (ld_done),
        .ld_err   (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full load: ld_start, one idle LOAD cycle, then 16 words (optionally with
    // an idle cycle before each), then the checksum word when the feature is built in.
    task automatic do_load(input logic [7:0] base, input bit same, input bit toggle,
                           input bit restart3, input logic [7:0] csum, input int exp_hold);
        int holds;
        int dones;
        ld_start = 1'b1;
        ld_valid = 1'b0;
        tick();
        ld_start = 1'b0;
        chk("err_clr_on_start", ld_err, 0);
        chk("ready_in_load", ld_ready, 1);
        chk("dout_zero_in_load", dout, 0);
        holds = 0;
        dones = 0;
        holds += int'(cpu_hold);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (toggle) begin
                ld_valid = 1'b0;
                holds += int'(cpu_hold);
                dones += int'(ld_done);
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = same ? base : base + 8'(i);
            if (restart3 && i == 3) ld_start = 1'b1;
            holds += int'(cpu_hold);
            dones += int'(ld_done);
            tick();
            ld_start = 1'b0;
        end
        if (EXTRA == 1) begin
            chk("ready_in_check", ld_ready, 1);
            ld_valid = 1'b1;
            ld_data  = csum;
            holds += int'(cpu_hold);
            dones += int'(ld_done);
            tick();
        end
        ld_valid = 1'b0;
        chk("done_not_early", dones, 0);
        chk("done_pulse", ld_done, 1);
        chk("hold_low_after", cpu_hold, 0);
        chk("ready_low_after", ld_ready, 0);
        if (exp_hold > 0) chk("hold_cycles", holds, exp_hold);
        tick();
        chk("done_one_cycle", ld_done, 0);
    endtask

    task automatic check_image(input logic [7:0] base, input bit same);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            chk("image", dout, same ? base : base + 8'(a));
        end
    endtask

    initial begin
        n_reset  = 1'b0;
        address  = 4'd0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_err", ld_err, 0);
        #10;
        n_reset = 1'b1;
        tick();

        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            chk("sweep_dout", dout, 0);
            chk("sweep_hold", cpu_hold, 0);
            chk("sweep_ready", ld_ready, 0);
        end

        // Back-to-back image 0x10..0x1F.
        do_load(8'h10, 1'b0, 1'b0, 1'b0, 8'h88, 17 + EXTRA);
        address = 4'd5;
        #1;
        chk("addr5", dout, 8'h15);
        check_image(8'h10, 1'b0);
        if (EXTRA == 0) chk("err_tied_low", ld_err, 0);

        // Different image, ld_valid toggling every cycle.
        do_load(8'h40, 1'b0, 1'b1, 1'b0, 8'h00, 33 + EXTRA);
        check_image(8'h40, 1'b0);

        // Same image as the first load through the stalled path.
        do_load(8'h10, 1'b0, 1'b1, 1'b0, 8'h88, 0);
        check_image(8'h10, 1'b0);

        // Reset after 7 accepted words.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hA0 + 8'(i);
            tick();
        end
        ld_valid = 1'b0;
        chk("hold_before_rst", cpu_hold, 1);
        n_reset = 1'b0;
        #1;
        chk("midrst_hold", cpu_hold, 0);
        chk("midrst_ready", ld_ready, 0);
        chk("midrst_dout", dout, 0);
        #3;
        n_reset = 1'b1;
        begin
            int dones = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                dones += int'(ld_done);
            end
            chk("midrst_no_done", dones, 0);
        end
        chk("midrst_run", cpu_hold, 0);
        check_image(8'h00, 1'b1);

        // ld_start during word 3 is ignored.
        do_load(8'h60, 1'b0, 1'b0, 1'b1, 8'h00, 17 + EXTRA);
        check_image(8'h60, 1'b0);

`ifdef PROG_MEM_CHECKSUM_EN
        do_load(8'h01, 1'b1, 1'b0, 1'b0, 8'h10, 18);
        chk("csum_ok", ld_err, 0);
        check_image(8'h01, 1'b1);
        do_load(8'h01, 1'b1, 1'b0, 1'b0, 8'h11, 18);
        chk("csum_bad", ld_err, 1);
        tick();
        tick();
        chk("csum_bad_held", ld_err, 1);
        do_load(8'h20, 1'b0, 1'b0, 1'b0, 8'h78, 18);
        chk("csum_ok2", ld_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
